// File: rtl/demux_12_buf.sv
// One-to-two demultiplexer: each input word goes to the channel picked by s,
// and each channel buffers it in its own independent 2-entry FIFO.
module demux_12_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [1:0]       count0,
  output logic [1:0]       count1
);

  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       cnt [2];
  logic             wp  [2];
  logic             rp  [2];
  logic             push [2];
  logic             pop  [2];
  logic             full [2];

  always_comb begin
    full[0] = (cnt[0] == 2'd2);
    full[1] = (cnt[1] == 2'd2);
    // A pop in the same cycle does not free a slot for a full channel.
    in_ready = s ? !full[1] : !full[0];
    push[0] = in_valid && in_ready && !s;
    push[1] = in_valid && in_ready && s;
    pop[0]  = (cnt[0] != 2'd0) && out0_ready;
    pop[1]  = (cnt[1] != 2'd0) && out1_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c] <= 2'd0;
        wp[c]  <= 1'b0;
        rp[c]  <= 1'b0;
        mem[c][0] <= '0;
        mem[c][1] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wp[c]] <= din;
          wp[c] <= !wp[c];
        end
        if (pop[c]) begin
          rp[c] <= !rp[c];
        end
        if (push[c] && !pop[c]) begin
          cnt[c] <= cnt[c] + 2'd1;
        end else if (pop[c] && !push[c]) begin
          cnt[c] <= cnt[c] - 2'd1;
        end
      end
    end
  end

  assign out0_valid = (cnt[0] != 2'd0);
  assign out1_valid = (cnt[1] != 2'd0);
  assign out0_data  = mem[0][rp[0]];
  assign out1_data  = mem[1][rp[1]];
  assign count0     = cnt[0];
  assign count1     = cnt[1];

endmodule

// File: doc/demux_12_buf.md
DEMUX_12_BUF -- requirements
Module: demux_12_buf

Interface
REQ-001 Parameter: WIDTH, default 4, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: s  input  1  channel select; 0 routes the input word to channel 0, 1 routes it to channel 1.
REQ-005 Port: in_valid  input  1  input word present on din.
REQ-006 Port: din  input  WIDTH  input data word.
REQ-007 Port: in_ready  output  1  block can accept the word on din for the channel given by s.
REQ-008 Port: out0_valid  output  1  channel 0 holds at least one word.
REQ-009 Port: out0_data  output  WIDTH  oldest word held by channel 0.
REQ-010 Port: out0_ready  input  1  channel 0 consumer accepts out0_data.
REQ-011 Port: out1_valid / out1_data / out1_ready  same directions, widths and meanings as the channel-0 ports, for channel 1.
REQ-012 Port: count0, count1  output  2  number of words held by channel 0 and channel 1 (0..2).

Function
REQ-013 Each channel SHALL be an independent 2-entry FIFO with per-channel first-in, first-out ordering.
REQ-014 Input transfer: occurs on a rising edge when in_valid=1 and in_ready=1; the word SHALL be written to the channel selected by s at that edge.
REQ-015 in_ready is combinational: 1 when the selected channel's count < 2, else 0, independent of in_valid.
REQ-016 When in_ready=0, din SHALL be ignored and no channel state changes due to input.
REQ-017 outN_valid = (countN != 0); outN_data = head entry of channel N; outN_data is don't-care when outN_valid=0.
REQ-018 Output transfer: occurs on a rising edge when outN_valid=1 and outN_ready=1; the head entry is removed.
REQ-019 Latency: a word accepted at edge k into an empty channel SHALL appear on outN_valid/outN_data immediately after edge k (one cycle, no combinational bypass from din).
REQ-020 Simultaneous push and pop on the same channel (count 1): count stays 1 and the new word becomes head after the edge.
REQ-021 Full channel (count 2): in_ready=0 for that select even if the same cycle pops; no push-through when full.
REQ-022 Push to one channel and pop from the other in the same cycle SHALL both complete.
REQ-023 outN_ready asserted with outN_valid=0: no effect, count stays 0 (no underflow).
REQ-024 Read/write pointers wrap modulo 2; count SHALL never exceed 2 or go below 0.
REQ-025 s and din need not be stable when in_valid=0; s is sampled only at a transfer edge.

Reset
REQ-026 When rst=1 at a rising edge: count0=count1=0, out0_valid=out1_valid=0, pointers cleared, stored data discarded.
REQ-027 Reset SHALL take priority over any simultaneous push or pop at that edge; a word presented at a reset edge is lost.
REQ-028 During rst=1, in_ready SHALL reflect the empty state (1) after the first reset edge; no transfer is completed while rst=1.
REQ-029 Reset asserted mid-stream discards all held words; the first word after reset deassertion SHALL emerge as the head.

Verification
REQ-030 Reset, then s=0, din=4'h3, in_valid=1 for one edge -> out0_valid=1, out0_data=4'h3, count0=1, out1_valid=0.
REQ-031 Push 4'hA, 4'hB to channel 1 with out1_ready=0 -> count1=2, in_ready=0 for s=1 and in_ready=1 for s=0; third word 4'hC is not stored.
REQ-032 Channel 1 full, then out1_ready=1 for two edges -> out1_data shows 4'hA then 4'hB, count1 reaches 0, out1_valid=0.
REQ-033 Channel 0 holding 4'h1, push 4'h2 with out0_ready=1 in the same cycle -> count0 stays 1, out0_data=4'h2.
REQ-034 Both channels holding data, rst=1 for one edge with in_valid=1 -> count0=count1=0, both valid low, pushed word absent.
REQ-035 Alternating s=0/1 with 4'h0..4'h7 and both readies high -> channel 0 emits 0,2,4,6 and channel 1 emits 1,3,5,7, each one cycle after acceptance.
